uart_rx_fifo: RTL and testbench

//   Receive buffer downstream of the UART receiver. Captures one byte per rising edge of the

---
 rtl/uart_rx_fifo.sv | 72 +++++++
 tb/tb_uart_rx_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: one capture per rising edge of rx_valid,
// stored in a first-word-fall-through FIFO with fill level and sticky overrun reporting.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_BITS-1:0]  rx_data,
  input  logic                  rx_valid,
  output logic [DATA_BITS-1:0]  m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  vld_d;
  logic                  push;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;

  // Handshake: the head word transfers on any clock edge where m_valid and m_ready are
  // both high; m_data is held stable while m_valid is high and m_ready is low.
  assign push    = rx_valid & ~vld_d;
  assign pop     = m_valid & m_ready;
  assign wr_en   = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign m_valid = ~empty;
  assign m_data  = mem[rd_ptr];

  // Storage carries no reset; stale contents are masked by m_valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

  // vld_d resets high so a level already present at reset release is not taken as a byte.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      vld_d   <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      vld_d <= rx_valid;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DW = 8;
  localparam int DL = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [DL:0]   count;
  logic          full;
  logic          empty;
  logic          overrun;
  logic          clr_overrun;

  uart_rx_fifo #(.DATA_BITS(DW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
    .full(full), .empty(empty), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: stored words, popped words, sent words, overrun flag.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] sent_q[$];
  logic          exp_ovr;
  logic          prev_rx;
  logic          rand_ready;
  int            vectors;
  int            errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model from the inputs present at the edge, then compare.
  task automatic tick();
    bit            push, pop, was_full, hold;
    logic [DW-1:0] held;
    if (rand_ready) m_ready = ($urandom_range(0, 2) != 0);
    hold = m_valid && !m_ready && n_rst;
    held = m_data;
    if (!n_rst) begin
      exp_q.delete();
      exp_ovr = 1'b0;
      prev_rx = 1'b1;
    end else begin
      push     = rx_valid && !prev_rx;
      was_full = (exp_q.size() == DEPTH);
      pop      = (exp_q.size() > 0) && m_ready;
      if (pop) out_q.push_back(exp_q.pop_front());
      if (push) begin
        sent_q.push_back(rx_data);
        if (!was_full || pop) exp_q.push_back(rx_data);
      end
      if (push && was_full && !pop) exp_ovr = 1'b1;
      else if (clr_overrun)         exp_ovr = 1'b0;
      prev_rx = rx_valid;
    end
    @(posedge clk);
    #1;
    chk("count", count, exp_q.size());
    chk("empty", empty, exp_q.size() == 0);
    chk("full", full, exp_q.size() == DEPTH);
    chk("m_valid", m_valid, exp_q.size() != 0);
    chk("overrun", overrun, exp_ovr);
    if (exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
    if (hold && exp_q.size() != 0) chk("m_data_stable", m_data, held);
  endtask

  task automatic send_byte(input logic [DW-1:0] d, input int hold_cycles);
    rx_data  = d;
    rx_valid = 1'b1;
    repeat (hold_cycles) tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic drain();
    m_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    m_ready = 1'b0;
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < DEPTH; i++) send_byte(DW'(base + i), 2);
  endtask

  initial begin
    vectors = 0; errors = 0;
    exp_ovr = 1'b0; prev_rx = 1'b1; rand_ready = 1'b0;
    n_rst = 1'b0; rx_data = 8'h5A; rx_valid = 1'b1; m_ready = 1'b0; clr_overrun = 1'b0;

    // Reset with rx_valid high, then release while it stays high: no capture.
    repeat (2) tick();
    chk("rst_count", count, 0);
    chk("rst_m_valid", m_valid, 0);
    n_rst = 1'b1;
    repeat (5) tick();
    chk("no_capture_after_rst", count, 0);
    rx_valid = 1'b0;
    tick();

    // Single byte held 16 cycles: one push, visible one cycle after the rise.
    rx_data = 8'hA5; rx_valid = 1'b1;
    tick();
    chk("single_m_valid", m_valid, 1);
    chk("single_m_data", m_data, 8'hA5);
    repeat (15) tick();
    rx_valid = 1'b0;
    tick();
    chk("single_count", count, 1);
    drain();

    // Ordering and pointer wrap over three full rounds.
    for (int r = 0; r < 3; r++) begin
      fill(0);
      chk("round_full", full, 1);
      out_q.delete();
      drain();
      chk("round_pops", out_q.size(), DEPTH);
      for (int i = 0; i < DEPTH && i < out_q.size(); i++) chk("round_order", out_q[i], i);
    end

    // Overrun: drop while full, clear, then set and clear together.
    fill(8'h40);
    send_byte(8'h77, 2);
    chk("ovr_set", overrun, 1);
    chk("ovr_count", count, DEPTH);
    chk("ovr_head", m_data, 8'h40);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0; tick();
    chk("ovr_clr", overrun, 0);
    rx_data = 8'h78; rx_valid = 1'b1; clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0; rx_valid = 1'b0;
    tick();
    chk("ovr_set_wins", overrun, 1);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    drain();

    // Push coinciding with pop while full, and while holding a single word.
    fill(8'h80);
    rx_data = 8'h3C; rx_valid = 1'b1; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("simul_full_count", count, DEPTH);
    chk("simul_full_ovr", overrun, 0);
    rx_valid = 1'b0; tick();
    out_q.delete();
    drain();
    chk("simul_3c_last", out_q.size() > 0 ? out_q[out_q.size()-1] : 0, 8'h3C);
    send_byte(8'h11, 2);
    rx_data = 8'h22; rx_valid = 1'b1; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("simul_one_count", count, 1);
    chk("simul_one_head", m_data, 8'h22);
    rx_valid = 1'b0; tick();
    drain();

    // Random backpressure against 40 back-to-back random bytes.
    out_q.delete(); sent_q.delete();
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) send_byte(DW'($urandom), $urandom_range(1, 3));
    rand_ready = 1'b0;
    drain();
    if (!exp_ovr) begin
      chk("bp_len", out_q.size(), sent_q.size());
      for (int i = 0; i < sent_q.size() && i < out_q.size(); i++) chk("bp_order", out_q[i], sent_q[i]);
    end

    // Mid-operation reset discards contents.
    send_byte(8'hC3, 2);
    n_rst = 1'b0; tick(); n_rst = 1'b1;
    chk("midrst_m_valid", m_valid, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
